// File: rtl/mem_arbiter_pkg.sv
// Shared constants for mem_arbiter: access size codes, FSM state encoding and a size helper.
package mem_arbiter_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {StIdle, StAcc, StResp, StErr} state_e;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_HALF: size_bytes = 3'd2;
         SZ_BYTE: size_bytes = 3'd1;
         default: size_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-requester grant logic (fetch, data) with a last-grant flop; one-hot grant, bit 1 = data.
module mem_rr_arb
   import mem_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_if,
   input  logic       req_dm,
   input  logic       accept,
   output logic [1:0] grant
);

   // Reset value 0 means "fetch granted last", so data wins the first tie.
   logic last_dm_q;

   always_comb begin
      grant = 2'b00;
      if (req_if && req_dm) begin
         grant = (RR_EN && last_dm_q) ? 2'b01 : 2'b10;
      end else if (req_dm) begin
         grant = 2'b10;
      end else if (req_if) begin
         grant = 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_dm_q <= 1'b0;
      end else if (accept && (grant != 2'b00)) begin
         last_dm_q <= grant[1];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port; one access per IDLE-ACC-RESP pass.
// Optional build macro ALIGN_CHECK_EN rejects misaligned data accesses and zeroes misaligned fetches.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_BYTES     = 1024,
   parameter int unsigned RR_EN_DEFAULT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [1:0]  dm_size,
   input  logic        dm_sext,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ack,
   output logic [31:0] dm_rdata,
   output logic        dm_err,
   output logic        mem_w,
   output logic        mem_r,
   output logic        mem_s,
   output logic [1:0]  mem_c,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [1:0]  grant;
   logic        accept;
   logic        dm_bad;
   logic        if_mis;
   logic [32:0] dm_end;

   logic        gnt_dm_q, we_q, sext_q, zero_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, rdata_q;

   mem_rr_arb #(
      .RR_EN(RR_EN_DEFAULT != 0)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_if(if_req),
      .req_dm(dm_req),
      .accept(accept),
      .grant (grant)
   );

   assign accept = (state_q == StIdle) && (grant != 2'b00);
   assign dm_end = {1'b0, dm_addr} + {30'd0, size_bytes(dm_size)};

   always_comb begin
      dm_bad = (dm_size == SZ_ILL) || (dm_end > 33'(MEM_BYTES));
      if_mis = 1'b0;
`ifdef ALIGN_CHECK_EN
      if (((dm_size == SZ_WORD) && (dm_addr[1:0] != 2'b00)) ||
          ((dm_size == SZ_HALF) && dm_addr[0])) begin
         dm_bad = 1'b1;
      end
      if_mis = (if_addr[1:0] != 2'b00);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = (grant[1] && dm_bad) ? StErr : StAcc;
            end
         end
         StAcc:   state_d = StResp;
         StResp:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Requester fields are latched at grant so a dropped request cannot disturb the access.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_dm_q <= 1'b0;
         we_q     <= 1'b0;
         size_q   <= SZ_WORD;
         sext_q   <= 1'b0;
         zero_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         if (accept) begin
            if (grant[1]) begin
               gnt_dm_q <= 1'b1;
               we_q     <= dm_we;
               size_q   <= dm_size;
               sext_q   <= dm_sext;
               zero_q   <= 1'b0;
               addr_q   <= dm_addr;
               wdata_q  <= dm_wdata;
            end else begin
               gnt_dm_q <= 1'b0;
               we_q     <= 1'b0;
               size_q   <= SZ_WORD;
               sext_q   <= 1'b0;
               zero_q   <= if_mis;
               addr_q   <= if_addr % 32'(MEM_BYTES);
               wdata_q  <= '0;
            end
         end
         if (state_q == StAcc) begin
            rdata_q <= (we_q || zero_q) ? '0 : mem_rdata;
         end
      end
   end

   always_comb begin
      if_ack    = 1'b0;
      if_rdata  = '0;
      dm_ack    = 1'b0;
      dm_rdata  = '0;
      dm_err    = 1'b0;
      mem_w     = 1'b0;
      mem_r     = 1'b0;
      mem_s     = 1'b0;
      mem_c     = SZ_WORD;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = (state_q != StIdle);
      unique case (state_q)
         StAcc: begin
            mem_r     = ~we_q;
            mem_w     = we_q;
            mem_s     = sext_q & ~we_q;
            mem_c     = size_q;
            mem_addr  = addr_q;
            mem_wdata = we_q ? wdata_q : '0;
         end
         StResp: begin
            if (gnt_dm_q) begin
               dm_ack   = 1'b1;
               dm_rdata = rdata_q;
            end else begin
               if_ack   = 1'b1;
               if_rdata = rdata_q;
            end
         end
         StErr: begin
            dm_ack = 1'b1;
            dm_err = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array memory model that applies mem_c/mem_s sizing.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        dm_req, dm_we, dm_sext;
   logic [1:0]  dm_size;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        dm_err;
   logic        mem_w, mem_r, mem_s;
   logic [1:0]  mem_c;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [0:1023];
   logic        poke_en = 1'b0;
   logic [9:0]  poke_addr = '0;
   logic [31:0] poke_data = '0;
   logic [9:0]  ma;
   logic [15:0] mh;

   always #5 clk = ~clk;

   mem_arbiter #(
      .MEM_BYTES    (1024),
      .RR_EN_DEFAULT(1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_ack   (if_ack),
      .if_rdata (if_rdata),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_size  (dm_size),
      .dm_sext  (dm_sext),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_ack   (dm_ack),
      .dm_rdata (dm_rdata),
      .dm_err   (dm_err),
      .mem_w    (mem_w),
      .mem_r    (mem_r),
      .mem_s    (mem_s),
      .mem_c    (mem_c),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .busy     (busy)
   );

   assign ma = mem_addr[9:0];

   always_comb begin
      mem_rdata = '0;
      mh = {mem[ma + 10'd1], mem[ma]};
      case (mem_c)
         2'b00:   mem_rdata = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
         2'b01:   mem_rdata = {{16{mem_s & mh[15]}}, mh};
         2'b10:   mem_rdata = {{24{mem_s & mem[ma][7]}}, mem[ma]};
         default: mem_rdata = '0;
      endcase
   end

   always @(posedge clk) begin
      if (poke_en) begin
         for (int k = 0; k < 4; k++) mem[poke_addr + 10'(k)] <= poke_data[8*k +: 8];
      end else if (mem_w) begin
         case (mem_c)
            2'b00: for (int k = 0; k < 4; k++) mem[ma + 10'(k)] <= mem_wdata[8*k +: 8];
            2'b01: for (int k = 0; k < 2; k++) mem[ma + 10'(k)] <= mem_wdata[8*k +: 8];
            2'b10: mem[ma] <= mem_wdata[7:0];
            default: ;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_sext = 1'b0;
      dm_addr = '0; dm_wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic poke_word(input logic [9:0] a, input logic [31:0] d);
      poke_addr = a; poke_data = d; poke_en = 1'b1;
      tick();
      poke_en = 1'b0;
   endtask

   task automatic set_dm(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
      dm_we = we; dm_size = sz; dm_sext = sx; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
   endtask

   // Drives one data access from IDLE and records what the DUT did; leaves the DUT in IDLE.
   task automatic run_dm(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int ack_c, output logic [31:0] rd, output logic er,
                         output logic st_w, output logic st_r, output logic [31:0] m_addr);
      ack_c = -1; rd = '0; er = 1'b0; st_w = 1'b0; st_r = 1'b0; m_addr = '0;
      set_dm(we, sz, sx, a, wd);
      for (int c = 1; c <= 6 && ack_c < 0; c++) begin
         tick();
         if ((mem_r || mem_w) && !(st_r || st_w)) m_addr = mem_addr;
         st_w = st_w | mem_w;
         st_r = st_r | mem_r;
         if (dm_ack) begin ack_c = c; rd = dm_rdata; er = dm_err; end
      end
      dm_req = 1'b0;
      tick();
   endtask

   task automatic run_if(input logic [31:0] a, output int ack_c, output logic [31:0] rd,
                         output logic [31:0] m_addr);
      ack_c = -1; rd = '0; m_addr = '0;
      if_addr = a; if_req = 1'b1;
      for (int c = 1; c <= 6 && ack_c < 0; c++) begin
         tick();
         if (mem_r) m_addr = mem_addr;
         if (if_ack) begin ack_c = c; rd = if_rdata; end
      end
      if_req = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({if_ack, if_rdata, dm_ack, dm_rdata, dm_err, mem_w, mem_r, mem_s, mem_c, mem_addr,
           mem_wdata, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%0b mem_r=%0b mem_w=%0b if_ack=%0b dm_ack=%0b want all 0",
                  busy, mem_r, mem_w, if_ack, dm_ack);
      end
   endtask

   task automatic test_fetch();
      poke_word(10'h010, 32'h2008_0005);
      if_addr = 32'h10; if_req = 1'b1;
      tick();
      checks++;
      if ({mem_r, mem_w, mem_s, mem_c, busy} !== 6'b100001 || mem_addr !== 32'h10) begin
         errors++;
         $display("FAIL fetch_acc: got r=%0b w=%0b s=%0b c=%0b busy=%0b addr=%h want r=1 w=0 s=0 c=0 busy=1 addr=10",
                  mem_r, mem_w, mem_s, mem_c, busy, mem_addr);
      end
      tick();
      checks++;
      if (if_ack !== 1'b1 || if_rdata !== 32'h2008_0005 || dm_ack !== 1'b0 || mem_r !== 1'b0) begin
         errors++;
         $display("FAIL fetch_ack: got ack=%0b rdata=%h dm_ack=%0b mem_r=%0b want 1 20080005 0 0",
                  if_ack, if_rdata, dm_ack, mem_r);
      end
      if_req = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || if_ack !== 1'b0) begin
         errors++;
         $display("FAIL fetch_idle: got busy=%0b ack=%0b want 0 0", busy, if_ack);
      end
   endtask

   task automatic test_fetch_wrap();
      int ac; logic [31:0] rd, ad;
      run_if(32'h410, ac, rd, ad);
      checks++;
      if (ac !== 2 || rd !== 32'h2008_0005 || ad !== 32'h10) begin
         errors++;
         $display("FAIL fetch_wrap: got ack_cyc=%0d rdata=%h addr=%h want 2 20080005 00000010",
                  ac, rd, ad);
      end
   endtask

   task automatic test_both();
      int dm_at = -1, if_at = -1;
      logic both = 1'b0;
      logic [31:0] dv = '0, iv = '0;
      poke_word(10'h020, 32'h1122_3344);
      do_reset();
      if_addr = 32'h10; if_req = 1'b1;
      set_dm(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (dm_ack && if_ack) both = 1'b1;
         if (dm_ack) begin dm_at = c; dv = dm_rdata; dm_req = 1'b0; end
         if (if_ack) begin if_at = c; iv = if_rdata; if_req = 1'b0; end
      end
      checks++;
      if (dm_at !== 2 || if_at !== 5) begin
         errors++;
         $display("FAIL both_order: got dm_ack@%0d if_ack@%0d want 2 5", dm_at, if_at);
      end
      checks++;
      if (dv !== 32'h1122_3344 || iv !== 32'h2008_0005 || both !== 1'b0) begin
         errors++;
         $display("FAIL both_data: got dm=%h if=%h both=%0b want 11223344 20080005 0", dv, iv, both);
      end
   endtask

   task automatic test_rr();
      logic [17:0] log_v = '0, exp_v = '0;
      do_reset();
      if_addr = 32'h10; if_req = 1'b1;
      set_dm(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         log_v[2*c +: 2] = {dm_ack, if_ack};
      end
      idle_inputs();
      tick();
      exp_v[5:4]   = 2'b10;
      exp_v[11:10] = 2'b01;
      exp_v[17:16] = 2'b10;
      checks++;
      if (log_v !== exp_v) begin
         errors++;
         $display("FAIL rr_alternate: got ack log %b want %b", log_v, exp_v);
      end
   endtask

   task automatic test_sext();
      logic [1:0]  sz [3] = '{2'b10, 2'b10, 2'b01};
      logic        sx [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] ad [3] = '{32'h31, 32'h31, 32'h42};
      logic [31:0] ex [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
      int ac; logic [31:0] rd, ma_s; logic er, sw, sr;
      poke_word(10'h030, 32'h0000_8000);
      poke_word(10'h040, 32'h8001_0000);
      for (int i = 0; i < 3; i++) begin
         run_dm(1'b0, sz[i], sx[i], ad[i], 32'h0, ac, rd, er, sw, sr, ma_s);
         checks++;
         if (ac !== 2 || rd !== ex[i] || er !== 1'b0 || sr !== 1'b1 || sw !== 1'b0 || ma_s !== ad[i]) begin
            errors++;
            $display("FAIL sext_load%0d: got ack_cyc=%0d rdata=%h err=%0b r=%0b w=%0b addr=%h want 2 %h 0 1 0 %h",
                     i, ac, rd, er, sr, sw, ma_s, ex[i], ad[i]);
         end
      end
   endtask

   task automatic test_store();
      int ac; logic [31:0] rd, a; logic er, sw, sr;
      set_dm(1'b1, 2'b00, 1'b0, 32'h50, 32'hDEAD_BEEF);
      tick();
      checks++;
      if (mem_w !== 1'b1 || mem_r !== 1'b0 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h50) begin
         errors++;
         $display("FAIL store_acc: got w=%0b r=%0b wdata=%h addr=%h want 1 0 deadbeef 00000050",
                  mem_w, mem_r, mem_wdata, mem_addr);
      end
      tick();
      checks++;
      if (dm_ack !== 1'b1 || dm_rdata !== 32'h0 || dm_err !== 1'b0) begin
         errors++;
         $display("FAIL store_ack: got ack=%0b rdata=%h err=%0b want 1 0 0", dm_ack, dm_rdata, dm_err);
      end
      dm_req = 1'b0;
      tick();
      run_dm(1'b1, 2'b10, 1'b0, 32'h52, 32'h1234_56A5, ac, rd, er, sw, sr, a);
      run_dm(1'b0, 2'b00, 1'b0, 32'h50, 32'h0, ac, rd, er, sw, sr, a);
      checks++;
      if (ac !== 2 || rd !== 32'hDEA5_BEEF) begin
         errors++;
         $display("FAIL store_readback: got ack_cyc=%0d rdata=%h want 2 dea5beef", ac, rd);
      end
   endtask

   task automatic test_err();
      int ac; logic [31:0] rd, a; logic er, sw, sr;
      run_dm(1'b1, 2'b11, 1'b0, 32'h50, 32'hFFFF_FFFF, ac, rd, er, sw, sr, a);
      checks++;
      if (ac !== 1 || er !== 1'b1 || rd !== 32'h0 || sw !== 1'b0 || sr !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL err_size: got ack_cyc=%0d err=%0b rdata=%h w=%0b r=%0b busy=%0b want 1 1 0 0 0 0",
                  ac, er, rd, sw, sr, busy);
      end
      run_dm(1'b0, 2'b00, 1'b0, 32'h3FE, 32'h0, ac, rd, er, sw, sr, a);
      checks++;
      if (ac !== 1 || er !== 1'b1 || sr !== 1'b0) begin
         errors++;
         $display("FAIL err_range_word: got ack_cyc=%0d err=%0b r=%0b want 1 1 0", ac, er, sr);
      end
      poke_word(10'h3FC, 32'hCAFE_F00D);
      run_dm(1'b0, 2'b00, 1'b0, 32'h3FC, 32'h0, ac, rd, er, sw, sr, a);
      checks++;
      if (ac !== 2 || er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL edge_word_ok: got ack_cyc=%0d err=%0b rdata=%h want 2 0 cafef00d", ac, er, rd);
      end
      run_dm(1'b0, 2'b10, 1'b0, 32'h3FF, 32'h0, ac, rd, er, sw, sr, a);
      checks++;
      if (ac !== 2 || er !== 1'b0 || rd !== 32'h0000_00CA) begin
         errors++;
         $display("FAIL edge_byte_ok: got ack_cyc=%0d err=%0b rdata=%h want 2 0 000000ca", ac, er, rd);
      end
      run_dm(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, ac, rd, er, sw, sr, a);
      checks++;
      if (ac !== 1 || er !== 1'b1 || sr !== 1'b0) begin
         errors++;
         $display("FAIL err_range_byte: got ack_cyc=%0d err=%0b r=%0b want 1 1 0", ac, er, sr);
      end
   endtask

   task automatic test_reset_acc();
      int ac; logic [31:0] rd, a;
      logic seen_ack = 1'b0;
      set_dm(1'b1, 2'b00, 1'b0, 32'h60, 32'h55AA_55AA);
      tick();
      checks++;
      if (mem_w !== 1'b1) begin
         errors++;
         $display("FAIL rstacc_strobe: got mem_w=%0b want 1", mem_w);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dm_req = 1'b0;
      checks++;
      if (busy !== 1'b0 || dm_ack !== 1'b0 || mem_w !== 1'b0) begin
         errors++;
         $display("FAIL rstacc_idle: got busy=%0b dm_ack=%0b mem_w=%0b want 0 0 0", busy, dm_ack, mem_w);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         seen_ack = seen_ack | dm_ack;
      end
      checks++;
      if (seen_ack !== 1'b0 || {mem[10'h063], mem[10'h062], mem[10'h061], mem[10'h060]} !== 32'h55AA_55AA) begin
         errors++;
         $display("FAIL rstacc_noack: got late_ack=%0b stored=%h want 0 55aa55aa", seen_ack,
                  {mem[10'h063], mem[10'h062], mem[10'h061], mem[10'h060]});
      end
      run_if(32'h10, ac, rd, a);
      checks++;
      if (ac !== 2 || rd !== 32'h2008_0005) begin
         errors++;
         $display("FAIL rstacc_fetch: got ack_cyc=%0d rdata=%h want 2 20080005", ac, rd);
      end
   endtask

   task automatic test_drop();
      set_dm(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
      tick();
      dm_req = 1'b0;
      tick();
      checks++;
      if (dm_ack !== 1'b1 || dm_rdata !== 32'h1122_3344) begin
         errors++;
         $display("FAIL drop_no_abort: got ack=%0b rdata=%h want 1 11223344", dm_ack, dm_rdata);
      end
      tick();
   endtask

   task automatic test_misalign();
      int ac; logic [31:0] rd, a; logic er, sw, sr;
      poke_word(10'h100, 32'h3322_1100);
      poke_word(10'h104, 32'h7766_5544);
      run_dm(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, ac, rd, er, sw, sr, a);
`ifdef ALIGN_CHECK_EN
      checks++;
      if (ac !== 1 || er !== 1'b1 || sr !== 1'b0) begin
         errors++;
         $display("FAIL misalign_word: got ack_cyc=%0d err=%0b r=%0b want 1 1 0", ac, er, sr);
      end
      run_if(32'h102, ac, rd, a);
      checks++;
      if (ac !== 2 || rd !== 32'h0) begin
         errors++;
         $display("FAIL misalign_fetch: got ack_cyc=%0d rdata=%h want 2 0", ac, rd);
      end
`else
      checks++;
      if (ac !== 2 || er !== 1'b0 || sr !== 1'b1 || a !== 32'h102 || rd !== 32'h5544_3322) begin
         errors++;
         $display("FAIL misalign_word: got ack_cyc=%0d err=%0b r=%0b addr=%h rdata=%h want 2 0 1 102 55443322",
                  ac, er, sr, a, rd);
      end
      run_if(32'h102, ac, rd, a);
      checks++;
      if (ac !== 2 || rd !== 32'h5544_3322) begin
         errors++;
         $display("FAIL misalign_fetch: got ack_cyc=%0d rdata=%h want 2 55443322", ac, rd);
      end
`endif
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_fetch();
      test_fetch_wrap();
      test_both();
      test_rr();
      test_sext();
      test_store();
      test_err();
      test_reset_acc();
      test_drop();
      test_misalign();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
